sap_controller_sequencer: RTL and testbench
===========================================

// Module: sap_controller_sequencer
// PURPOSE
//  Upstream control stage of the 8-bit CPU; generates the program counter's
//  cp/ep/lp strobes and every other bus/load strobe.
//  Six-state one-hot ring counter (T1..T6) sequences fetch and execute.
//  Decodes the instruction register opcode nibble during T4..T6.
//  Freezes permanently on HLT until reset.
// PARAMETERS
//  OPC_LDA  4'h0  load A from memory[operand]
//  OPC_ADD  4'h1  A <= A + memory[operand]
//  OPC_SUB  4'h2  A <= A - memory[operand]
//  OPC_JMP  4'h3  PC <= operand
//  OPC_OUT  4'hE  output register <= A
//  OPC_HLT  4'hF  stop sequencing
// PORTS
//  clk      in   1  clock; all state updates on rising edge
//  rst_n    in   1  asynchronous active-low reset
//  opcode   in   4  IR upper nibble; must be stable from T4 through T6
//  run      in   1  1 = advance one T-state per clock
//  step     in   1  with run=0: advance exactly one T-state on this edge
//  cp       out  1  PC count enable
//  ep       out  1  PC drive to bus
//  lp       out  1  PC load from bus
//  lm       out  1  MAR load
//  ce       out  1  RAM drive to bus
//  li       out  1  IR load
//  ei       out  1  IR operand drive to bus
//  la       out  1  A register load
//  ea       out  1  A register drive to bus
//  su       out  1  ALU subtract select
//  eu       out  1  ALU drive to bus
//  lb       out  1  B register load
//  lo       out  1  output register load
//  t_state  out  6  one-hot ring state; bit0 = T1
//  halted   out  1  HLT has been executed
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous):
//  - t_state=6'b000001, halted=0.
//  - All control outputs 0 while rst_n is low.
//  Advance condition: adv = ~halted & (run | step).
//  - If adv is 1, ring rotates T1->T2->...->T6->T1 on the clock edge.
//  - Otherwise t_state holds.
//  Control outputs:
//  - Combinational from t_state and opcode.
//  - Gated by adv: all 0 whenever adv=0. No strobe repeats while frozen.
//  - Fetch, all opcodes: T1 ep,lm | T2 cp | T3 ce,li.
//  - LDA: T4 ei,lm | T5 ce,la | T6 none.
//  - ADD: T4 ei,lm | T5 ce,lb | T6 eu,la (su=0).
//  - SUB: T4 ei,lm | T5 ce,lb | T6 eu,la,su.
//  - JMP: T4 ei,lp | T5,T6 none.
//  - OUT: T4 ea,lo | T5,T6 none.
//  - Unlisted opcodes: NOP, T4..T6 none.
//  - HLT: at T4 with adv=1, halted<=1 and ring holds at T4; all controls 0 thereafter.
//  Bus rule: at most one of ep/ce/ei/ea/eu is high in any cycle.
//  Pausing and stepping:
//  - run dropped mid-instruction: freeze at current T-state; resume there, no lost or repeated strobe.
//  - step and run both high: same as run.
//  Reset mid-instruction: immediately T1, controls 0, halted cleared.
// TESTING
//  1. Reset, run=1, opcode=0 -> T1{ep,lm}, T2{cp}, T3{ce,li}, T4{ei,lm}, T5{ce,la}, T6{}, then T1.
//  2. opcode=2, run=1 through T6 -> T5{ce,lb}, T6{eu,la,su}; cp high on exactly 1 of 6 cycles.
//  3. opcode=3 -> T4 {ei,lp} only; opcode=E -> T4 {ea,lo}; opcode=7 -> T4..T6 all zero.
//  4. opcode=F, run=1 -> halted=1 after T4 edge, t_state=6'b001000 held, all controls 0 for 20 cycles.
//  5. run=0 at T2 for 5 cycles -> cp=0 throughout; step pulse -> cp high 1 cycle, then T3.
//  6. rst_n low mid-T5 (asynchronous, between edges) -> t_state=000001, controls 0 immediately, halted=0.
//  Assertion: one-hot t_state and the bus rule checked every cycle.

Source files
------------

// File: rtl/sap_controller_sequencer.sv
// Control sequencer for the 8-bit SAP CPU: a six-state one-hot ring (T1..T6)
// that emits fetch/execute strobes from the current T-state and IR opcode.
module sap_controller_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic       run,
    input  logic       step,
    output logic       cp,
    output logic       ep,
    output logic       lp,
    output logic       lm,
    output logic       ce,
    output logic       li,
    output logic       ei,
    output logic       la,
    output logic       ea,
    output logic       su,
    output logic       eu,
    output logic       lb,
    output logic       lo,
    output logic [5:0] t_state,
    output logic       halted
);
    localparam logic [3:0] OPC_LDA = 4'h0;
    localparam logic [3:0] OPC_ADD = 4'h1;
    localparam logic [3:0] OPC_SUB = 4'h2;
    localparam logic [3:0] OPC_JMP = 4'h3;
    localparam logic [3:0] OPC_OUT = 4'hE;
    localparam logic [3:0] OPC_HLT = 4'hF;

    logic [5:0] t_state_reg;
    logic [5:0] t_state_next;
    logic       halted_reg;
    logic       adv;
    logic       strobe_en;
    logic       hlt_at_t4;

    assign adv       = ~halted_reg & (run | step);
    assign hlt_at_t4 = adv & t_state_reg[3] & (opcode == OPC_HLT);
    // Strobes are suppressed while reset is asserted even though the ring sits at T1.
    assign strobe_en = adv & rst_n;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_ring
            assign t_state_next[gi] = t_state_reg[(gi + 5) % 6];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_state_reg <= 6'b000001;
            halted_reg  <= 1'b0;
        end else if (hlt_at_t4) begin
            halted_reg  <= 1'b1;
        end else if (adv) begin
            t_state_reg <= t_state_next;
        end
    end

    always_comb begin
        cp = 1'b0; ep = 1'b0; lp = 1'b0; lm = 1'b0; ce = 1'b0;
        li = 1'b0; ei = 1'b0; la = 1'b0; ea = 1'b0; su = 1'b0;
        eu = 1'b0; lb = 1'b0; lo = 1'b0;
        if (strobe_en) begin
            if (t_state_reg[0]) begin
                ep = 1'b1; lm = 1'b1;
            end
            if (t_state_reg[1]) cp = 1'b1;
            if (t_state_reg[2]) begin
                ce = 1'b1; li = 1'b1;
            end
            if (t_state_reg[3]) begin
                case (opcode)
                    OPC_LDA, OPC_ADD, OPC_SUB: begin
                        ei = 1'b1; lm = 1'b1;
                    end
                    OPC_JMP: begin
                        ei = 1'b1; lp = 1'b1;
                    end
                    OPC_OUT: begin
                        ea = 1'b1; lo = 1'b1;
                    end
                    default: ;
                endcase
            end
            if (t_state_reg[4]) begin
                case (opcode)
                    OPC_LDA: begin
                        ce = 1'b1; la = 1'b1;
                    end
                    OPC_ADD, OPC_SUB: begin
                        ce = 1'b1; lb = 1'b1;
                    end
                    default: ;
                endcase
            end
            if (t_state_reg[5] && (opcode == OPC_ADD || opcode == OPC_SUB)) begin
                eu = 1'b1; la = 1'b1;
                su = (opcode == OPC_SUB);
            end
        end
    end

    assign t_state = t_state_reg;
    assign halted  = halted_reg;
endmodule

// File: tb/tb_sap_controller_sequencer.sv
// Bench for sap_controller_sequencer: directed scenarios plus randomized run/step/opcode
// traffic compared cycle by cycle against a T-step-number reference model.
module tb_sap_controller_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic cp, ep, lp, lm, ce, li, ei, la, ea, su, eu, lb, lo, halted;
    logic [5:0] t_state;

    localparam int CP = 12, EP = 11, LP = 10, LM = 9, CE = 8, LI = 7, EI = 6,
                   LA = 5, EA = 4, SU = 3, EU = 2, LB = 1, LO = 0;

    int n_cmp = 0;
    int n_bad = 0;
    int m_t = 1;       // reference T-step number, 1..6
    bit m_halt = 1'b0;

    sap_controller_sequencer dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .run(run), .step(step),
        .cp(cp), .ep(ep), .lp(lp), .lm(lm), .ce(ce), .li(li), .ei(ei),
        .la(la), .ea(ea), .su(su), .eu(eu), .lb(lb), .lo(lo),
        .t_state(t_state), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Strobe table written straight from the instruction timing chart.
    function automatic logic [12:0] ref_ctrl(int t, logic [3:0] op, bit en);
        logic [12:0] v;
        v = '0;
        if (en) begin
            case (t)
                1: begin v[EP] = 1; v[LM] = 1; end
                2: v[CP] = 1;
                3: begin v[CE] = 1; v[LI] = 1; end
                4: case (op)
                       4'h0, 4'h1, 4'h2: begin v[EI] = 1; v[LM] = 1; end
                       4'h3: begin v[EI] = 1; v[LP] = 1; end
                       4'hE: begin v[EA] = 1; v[LO] = 1; end
                       default: ;
                   endcase
                5: case (op)
                       4'h0: begin v[CE] = 1; v[LA] = 1; end
                       4'h1, 4'h2: begin v[CE] = 1; v[LB] = 1; end
                       default: ;
                   endcase
                6: if (op == 4'h1 || op == 4'h2) begin
                       v[EU] = 1; v[LA] = 1; v[SU] = (op == 4'h2);
                   end
                default: ;
            endcase
        end
        return v;
    endfunction

    function automatic logic [12:0] dut_ctrl();
        return {cp, ep, lp, lm, ce, li, ei, la, ea, su, eu, lb, lo};
    endfunction

    task automatic check_outputs(input string tag);
        bit en;
        en = rst_n && !m_halt && (run || step);
        check_eq({tag, ".t_state"}, 32'(t_state), 32'(6'b1 << (m_t - 1)));
        check_eq({tag, ".halted"}, 32'(halted), 32'(m_halt));
        check_eq({tag, ".ctrl"}, 32'(dut_ctrl()), 32'(ref_ctrl(m_t, opcode, en)));
        check_eq({tag, ".onehot"}, 32'($onehot(t_state)), 32'd1);
        check_eq({tag, ".bus"}, 32'($countones({ep, ce, ei, ea, eu}) <= 1), 32'd1);
    endtask

    // Entered just after a falling edge with inputs already set.
    task automatic tick(input string tag);
        bit adv;
        #1;
        check_outputs(tag);
        adv = rst_n && !m_halt && (run || step);
        @(posedge clk);
        if (adv) begin
            if (m_t == 4 && opcode == 4'hF) m_halt = 1'b1;
            else m_t = (m_t == 6) ? 1 : m_t + 1;
        end
        @(negedge clk);
    endtask

    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        m_t = 1;
        m_halt = 1'b0;
        #1;
        check_outputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int cp_cnt;
        logic [3:0] ops [8];
        ops[0] = 4'h0; ops[1] = 4'h1; ops[2] = 4'h2; ops[3] = 4'h3;
        ops[4] = 4'hE; ops[5] = 4'h7; ops[6] = 4'hF; ops[7] = 4'h0;

        // 1: reset state, then one LDA instruction plus wrap to T1
        run = 1'b1;
        @(negedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        opcode = 4'h0;
        for (int i = 0; i < 7; i++) tick("lda");

        // 2: SUB, count cp pulses over one instruction
        opcode = 4'h2;
        cp_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            #1 cp_cnt += int'(cp);
            tick("sub");
        end
        check_eq("sub.cp_count", 32'(cp_cnt), 32'd1);

        // 3: JMP, OUT, unlisted NOP
        opcode = 4'h3; for (int i = 0; i < 6; i++) tick("jmp");
        opcode = 4'hE; for (int i = 0; i < 6; i++) tick("out");
        opcode = 4'h7; for (int i = 0; i < 6; i++) tick("nop");
        opcode = 4'h1; for (int i = 0; i < 6; i++) tick("add");

        // 4: HLT freezes at T4
        opcode = 4'hF;
        for (int i = 0; i < 24; i++) tick("hlt");
        check_eq("hlt.t_state", 32'(t_state), 32'h08);

        // 6a: async reset between edges clears halted
        #2 rst_n = 1'b0;
        m_t = 1; m_halt = 1'b0;
        #1 check_outputs("areset_halt");
        @(negedge clk);
        rst_n = 1'b1;

        // 5: pause at T2, then single step
        opcode = 4'h0;
        tick("p.t1");
        run = 1'b0;
        for (int i = 0; i < 5; i++) tick("pause");
        step = 1'b1;
        tick("step");
        step = 1'b0;
        tick("after_step");
        check_eq("step.at_t3", 32'(t_state), 32'h04);
        run = 1'b1;
        tick("resume");

        // 6b: async reset mid-T5
        while (m_t != 5) tick("to_t5");
        #2 rst_n = 1'b0;
        m_t = 1;
        #1 check_outputs("areset_t5");
        @(posedge clk);
        #1 check_outputs("areset_hold");
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic; opcode only changes during fetch
        for (int i = 0; i < 600; i++) begin
            if (m_t <= 3 && $urandom_range(0, 2) == 0) opcode = ops[$urandom_range(0, 7)];
            if (m_t <= 3 && $urandom_range(0, 9) == 0) opcode = 4'($urandom);
            run  = ($urandom_range(0, 3) != 0);
            step = ($urandom_range(0, 2) == 0);
            if (m_halt && $urandom_range(0, 5) == 0) pulse_reset("rnd.reset");
            else if ($urandom_range(0, 99) == 0) pulse_reset("rnd.reset");
            else tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
